// File: rtl/rr3_grant_sched.sv
// Three-way round-robin grant scheduler with a bounded hold time.
// One-hot registered grants; an owner holding past MAX_HOLD cycles is revoked.
module rr3_grant_sched #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [2:0] req,
  // "release" is a reserved word in SystemVerilog, hence the short name.
  input  logic       rel,
  output logic [2:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic [1:0] ptr,
  output logic       revoked
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             revoked_q, revoked_d;

  logic [1:0] prio0, prio1, prio2;
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    inc3 = (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // A corrupted pointer value of 3 arbitrates as if it were 0.
  always_comb begin
    prio0   = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    prio1   = inc3(prio0);
    prio2   = inc3(prio1);
    any_req = |req;
    if (req[prio0]) begin
      winner = prio0;
    end else if (req[prio1]) begin
      winner = prio1;
    end else begin
      winner = prio2;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    unique case (gnt_id_q)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    revoked_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && any_req) begin
          state_d     = StGrant;
          gnt_d       = 3'b001 << winner;
          gnt_valid_d = 1'b1;
          gnt_id_d    = winner;
          ptr_d       = inc3(winner);
          cnt_d       = '0;
        end
      end
      StGrant: begin
        if (rel || !owner_req) begin
          state_d     = StIdle;
          gnt_d       = 3'b000;
          gnt_valid_d = 1'b0;
          gnt_id_d    = 2'd0;
          cnt_d       = '0;
        end else if (cnt_q == HoldLast) begin
          state_d     = StIdle;
          gnt_d       = 3'b000;
          gnt_valid_d = 1'b0;
          gnt_id_d    = 2'd0;
          cnt_d       = '0;
          revoked_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        gnt_d       = 3'b000;
        gnt_valid_d = 1'b0;
        gnt_id_d    = 2'd0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gnt_q       <= 3'b000;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      ptr_q       <= 2'd0;
      revoked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
      revoked_q   <= revoked_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign ptr       = ptr_q;
  assign revoked   = revoked_q;

endmodule

// File: tb/tb_rr3_grant_sched.sv
// Directed bench for rr3_grant_sched with MAX_HOLD=4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rr3_grant_sched;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] req;
  logic       rel;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [1:0] ptr;
  logic       revoked;

  int vectors;
  int miscompares;

  rr3_grant_sched #(
    .MAX_HOLD(4),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .req      (req),
    .rel      (rel),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .ptr      (ptr),
    .revoked  (revoked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    req     = 3'b000;
    rel     = 1'b0;
    #12;
    vectors++;
    if ({gnt, gnt_valid, gnt_id, ptr, revoked} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_state: got gnt=%b v=%b id=%0d ptr=%0d rev=%b, want all zero",
               gnt, gnt_valid, gnt_id, ptr, revoked);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    vectors++;
    if (gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got gnt=%b, want 000", gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    en  = 1'b1;
    req = 3'b001;
    step();
    vectors++;
    if (gnt !== 3'b001 || ptr !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_grant_pre: got gnt=%b ptr=%0d, want 001 ptr=1", gnt, ptr);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== 3'b000 || gnt_valid !== 1'b0 || ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_grant_reset: got gnt=%b v=%b ptr=%0d, want 000 0 0",
               gnt, gnt_valid, ptr);
    end
    req = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rotation();
    logic [2:0] exp_gnt [7];
    logic [1:0] exp_ptr [7];
    exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    exp_ptr = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
    en  = 1'b1;
    req = 3'b111;
    rel = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i] || ptr !== exp_ptr[i] || gnt_valid !== (exp_gnt[i] != 3'b000)) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got gnt=%b ptr=%0d v=%b, want gnt=%b ptr=%0d",
                 i, gnt, ptr, gnt_valid, exp_gnt[i], exp_ptr[i]);
      end
    end
    rel = 1'b0;
    req = 3'b000;
    step();
  endtask

  task automatic test_timeout();
    // ptr=1 here; requester 1 wins, holds 4 cycles, is revoked, then re-granted.
    req = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (gnt !== 3'b010 || gnt_id !== 2'd1 || revoked !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold[%0d]: got gnt=%b id=%0d rev=%b, want 010 1 0",
                 i, gnt, gnt_id, revoked);
      end
    end
    step();
    vectors++;
    if (gnt !== 3'b000 || revoked !== 1'b1 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_revoke: got gnt=%b rev=%b v=%b, want 000 1 0",
               gnt, revoked, gnt_valid);
    end
    step();
    vectors++;
    if (gnt !== 3'b010 || revoked !== 1'b0 || ptr !== 2'd2) begin
      miscompares++;
      $display("FAIL timeout_regrant: got gnt=%b rev=%b ptr=%0d, want 010 0 2",
               gnt, revoked, ptr);
    end
  endtask

  task automatic test_release_collision();
    // Continues the grant from test_timeout, which is in its first cycle.
    step();
    step();
    step();
    vectors++;
    if (gnt !== 3'b010) begin
      miscompares++;
      $display("FAIL collide_4th: got gnt=%b, want 010", gnt);
    end
    rel = 1'b1;
    step();
    vectors++;
    if (gnt !== 3'b000 || revoked !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_end: got gnt=%b rev=%b, want 000 0", gnt, revoked);
    end
    rel = 1'b0;
    req = 3'b000;
    step();
  endtask

  task automatic test_ptr_priority();
    req = 3'b011;
    step();
    vectors++;
    if (gnt !== 3'b001 || gnt_id !== 2'd0 || ptr !== 2'd1) begin
      miscompares++;
      $display("FAIL prio_first: got gnt=%b id=%0d ptr=%0d, want 001 0 1", gnt, gnt_id, ptr);
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    vectors++;
    if (gnt !== 3'b010 || gnt_id !== 2'd1 || ptr !== 2'd2) begin
      miscompares++;
      $display("FAIL prio_second: got gnt=%b id=%0d ptr=%0d, want 010 1 2", gnt, gnt_id, ptr);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_en_gating();
    en  = 1'b0;
    req = 3'b100;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (gnt !== 3'b000 || gnt_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_low[%0d]: got gnt=%b v=%b, want 000 0", i, gnt, gnt_valid);
      end
    end
    en = 1'b1;
    step();
    vectors++;
    if (gnt !== 3'b100 || gnt_id !== 2'd2 || ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL en_grant: got gnt=%b id=%0d ptr=%0d, want 100 2 0", gnt, gnt_id, ptr);
    end
    req = 3'b000;
    step();
    vectors++;
    if (gnt !== 3'b000 || revoked !== 1'b0) begin
      miscompares++;
      $display("FAIL req_drop: got gnt=%b rev=%b, want 000 0", gnt, revoked);
    end
  endtask

  task automatic test_en_drop_in_grant();
    req = 3'b100;
    step();
    en  = 1'b0;
    req = 3'b110;
    step();
    vectors++;
    if (gnt !== 3'b100 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL en_drop_hold: got gnt=%b v=%b, want 100 1", gnt, gnt_valid);
    end
    req = 3'b000;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_reset_mid_grant();
    test_rotation();
    test_timeout();
    test_release_collision();
    test_ptr_priority();
    test_en_gating();
    test_en_drop_in_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
